// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data memory controller: FSM state encoding,
// latency counter width and byte-address to word-index conversion.
package dmem_pkg;

   localparam int LAT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Full word offset of a byte address; callers keep only the index bits they need.
   function automatic logic [31:0] word_idx(input logic [31:0] addr);
      return addr >> 2;
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response handshake bundle between the load/store unit (master)
// and the data memory controller (slave).
interface dmem_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 32
);
   logic               req_valid;
   logic               req_ready;
   logic               req_we;
   logic [AW-1:0]      req_addr;
   logic [WIDTH/8-1:0] req_be;
   logic [WIDTH-1:0]   req_wdata;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [WIDTH-1:0]   rsp_rdata;
   logic               rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_ctrl_mem_array.sv
// DEPTH x WIDTH backing RAM: per-byte synchronous write, asynchronous read
// on a single shared word index.
module mem_array #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 32,
   localparam int NB    = WIDTH / 8,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic [NB-1:0]    i_be,
   input  logic [IDX_W-1:0] i_idx,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // NOTE: the array has no reset branch; clearing it would turn the RAM into flops.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int i = 0; i < NB; i++) begin
            if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: one outstanding request, programmable wait cycles,
// byte-lane stores and misaligned/out-of-range error reporting.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int WIDTH   = 32,
   parameter int LATENCY = 1,
   parameter int AW      = 32
) (
   input  logic        clk,
   input  logic        reset,
   dmem_ctrl_if.slave  bus
);

   localparam int NB    = WIDTH / 8;
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

   logic [1:0]       r_state;
   logic [LAT_W-1:0] r_cnt;
   logic             r_we;
   logic [AW-1:0]    r_addr;
   logic [NB-1:0]    r_be;
   logic [WIDTH-1:0] r_wdata;
   logic [WIDTH-1:0] r_rdata;
   logic             r_err;

   logic             w_accept;
   logic             w_to_resp;
   logic             w_cur_we;
   logic [AW-1:0]    w_cur_addr;
   logic [NB-1:0]    w_cur_be;
   logic [WIDTH-1:0] w_cur_wdata;
   logic [IDX_W-1:0] w_idx;
   logic             w_err;
   logic             w_mem_we;
   logic [WIDTH-1:0] w_rd_word;
   logic [WIDTH-1:0] w_merged;

   assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
   assign w_to_resp = (LATENCY == 0) ? w_accept : ((r_state == S_WAIT) && (r_cnt == '0));

   // With zero latency the access completes on the accept edge, before the latch holds anything.
   always_comb begin
      w_cur_we    = r_we;
      w_cur_addr  = r_addr;
      w_cur_be    = r_be;
      w_cur_wdata = r_wdata;
      if (r_state == S_IDLE) begin
         w_cur_we    = bus.req_we;
         w_cur_addr  = bus.req_addr;
         w_cur_be    = bus.req_be;
         w_cur_wdata = bus.req_wdata;
      end
   end

   assign w_idx    = IDX_W'(word_idx(32'(w_cur_addr)));
   assign w_err    = (w_cur_addr[1:0] != 2'b00) || ((w_cur_addr >> (IDX_W + 2)) != '0);
   assign w_mem_we = reset && w_to_resp && w_cur_we && !w_err;

   always_comb begin
      w_merged = w_rd_word;
      for (int i = 0; i < NB; i++) begin
         if (w_cur_be[i]) w_merged[8*i +: 8] = w_cur_wdata[8*i +: 8];
      end
   end

   mem_array #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_be    (w_cur_be),
      .i_idx   (w_idx),
      .i_wdata (w_cur_wdata),
      .o_rdata (w_rd_word)
   );

   // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_be    <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we    <= bus.req_we;
                  r_addr  <= bus.req_addr;
                  r_be    <= bus.req_be;
                  r_wdata <= bus.req_wdata;
                  r_cnt   <= LAT_INIT;
                  r_state <= (LATENCY == 0) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) r_state <= S_RESP;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            S_RESP: begin
               if (bus.rsp_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase

         if (w_to_resp) begin
            r_err   <= w_err;
            r_rdata <= w_err ? '0 : (w_cur_we ? w_merged : w_rd_word);
         end
      end
   end

   assign bus.req_ready = (r_state == S_IDLE);
   assign bus.rsp_valid = (r_state == S_RESP);
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: a LATENCY=2 instance for the main scenarios and
// a LATENCY=0 instance for the zero-wait path.
module tb_dmem_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        t_sel;        // 0 = LATENCY=2 instance, 1 = LATENCY=0 instance
   logic        t_valid;
   logic        t_we;
   logic [31:0] t_addr;
   logic [3:0]  t_be;
   logic [31:0] t_wdata;
   logic        t_rsp_ready;

   int n_total = 0;
   int n_bad   = 0;

   dmem_ctrl_if #(.WIDTH(32), .AW(32)) bus_l2 ();
   dmem_ctrl_if #(.WIDTH(32), .AW(32)) bus_l0 ();

   assign bus_l2.req_valid = t_valid && !t_sel;
   assign bus_l0.req_valid = t_valid && t_sel;
   assign bus_l2.req_we    = t_we;
   assign bus_l0.req_we    = t_we;
   assign bus_l2.req_addr  = t_addr;
   assign bus_l0.req_addr  = t_addr;
   assign bus_l2.req_be    = t_be;
   assign bus_l0.req_be    = t_be;
   assign bus_l2.req_wdata = t_wdata;
   assign bus_l0.req_wdata = t_wdata;
   assign bus_l2.rsp_ready = t_rsp_ready;
   assign bus_l0.rsp_ready = t_rsp_ready;

   dmem_ctrl #(.DEPTH(64), .WIDTH(32), .LATENCY(2), .AW(32)) dut_l2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_l2)
   );

   dmem_ctrl #(.DEPTH(64), .WIDTH(32), .LATENCY(0), .AW(32)) dut_l0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_l0)
   );

   logic        o_req_ready, o_rsp_valid, o_rsp_err;
   logic [31:0] o_rsp_rdata;
   assign o_req_ready = t_sel ? bus_l0.req_ready : bus_l2.req_ready;
   assign o_rsp_valid = t_sel ? bus_l0.rsp_valid : bus_l2.rsp_valid;
   assign o_rsp_err   = t_sel ? bus_l0.rsp_err   : bus_l2.rsp_err;
   assign o_rsp_rdata = t_sel ? bus_l0.rsp_rdata : bus_l2.rsp_rdata;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One request; returns at #1 after the edge where rsp_valid is first seen (hold=1)
   // or after the completing edge (hold=0). lat counts cycles from accept to rsp_valid.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic hold,
                         output logic [31:0] rdata, output logic err, output int lat);
      t_we        = we;
      t_addr      = addr;
      t_be        = be;
      t_wdata     = wdata;
      t_valid     = 1'b1;
      t_rsp_ready = !hold;
      @(posedge clk);
      #1;
      t_valid = 1'b0;
      t_addr  = 32'h0000_0003;   // scramble fields to prove the latched copies are used
      t_wdata = ~wdata;
      t_be    = ~be;
      t_we    = ~we;
      lat = 1;
      while (!o_rsp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!o_rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
      rdata = o_rsp_rdata;
      err   = o_rsp_err;
      if (!hold) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   logic [31:0] held;

   initial begin
      t_sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_addr = '0;
      t_be = '0; t_wdata = '0; t_rsp_ready = 1'b1;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(o_req_ready), 32'd1);
      check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_rsp_err",   32'(o_rsp_err),   32'd0);
      check("rst_rsp_rdata", o_rsp_rdata,      32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Store then load at 0x54 with LATENCY=2
      do_req(1'b1, 32'h54, 4'hF, 32'h7, 1'b0, rd, er, lat);
      check("st54_lat",   32'(lat), 32'd3);
      check("st54_rdata", rd, 32'h7);
      do_req(1'b0, 32'h54, 4'hF, 32'h0, 1'b0, rd, er, lat);
      check("ld54_lat",   32'(lat), 32'd3);
      check("ld54_rdata", rd, 32'h7);
      check("ld54_err",   32'(er), 32'd0);
      check("idle_ready", 32'(o_req_ready), 32'd1);

      // Store with no lanes enabled returns the current word unchanged
      do_req(1'b1, 32'h54, 4'h0, 32'hFFFF_FFFF, 1'b0, rd, er, lat);
      check("be0_rdata", rd, 32'h7);

      // Byte-lane merge
      do_req(1'b1, 32'h50, 4'hF, 32'hAABB_CCDD, 1'b0, rd, er, lat);
      check("st50_full", rd, 32'hAABB_CCDD);
      do_req(1'b1, 32'h50, 4'b0010, 32'h0000_1100, 1'b0, rd, er, lat);
      check("st50_lane1", rd, 32'hAABB_11DD);

      // Errors: misaligned load, out-of-range store aliasing word 0
      do_req(1'b1, 32'h0, 4'hF, 32'h1234_5678, 1'b0, rd, er, lat);
      do_req(1'b0, 32'h52, 4'hF, 32'h0, 1'b0, rd, er, lat);
      check("mis_err",   32'(er), 32'd1);
      check("mis_rdata", rd, 32'd0);
      do_req(1'b1, 32'h100, 4'hF, 32'hFFFF_FFFF, 1'b0, rd, er, lat);
      check("oor_err",   32'(er), 32'd1);
      check("oor_rdata", rd, 32'd0);
      do_req(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, rd, er, lat);
      check("w0_intact", rd, 32'h1234_5678);
      check("w0_err",    32'(er), 32'd0);

      // Backpressure in RESP
      do_req(1'b0, 32'h50, 4'hF, 32'h0, 1'b1, rd, er, lat);
      check("bp_rdata0", rd, 32'hAABB_11DD);
      held = o_rsp_rdata;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", 32'(o_rsp_valid), 32'd1);
         check("bp_ready", 32'(o_req_ready), 32'd0);
         check("bp_rdata", o_rsp_rdata, 32'hAABB_11DD);
      end
      t_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_rel_valid", 32'(o_rsp_valid), 32'd0);
      check("bp_rel_ready", 32'(o_req_ready), 32'd1);

      // Reset during WAIT of a store abandons it
      do_req(1'b1, 32'h40, 4'hF, 32'hCAFE_F00D, 1'b0, rd, er, lat);
      t_we = 1'b1; t_addr = 32'h40; t_be = 4'hF; t_wdata = 32'h0BAD_BEEF; t_valid = 1'b1;
      @(posedge clk);
      #1;
      t_valid = 1'b0;
      check("wait_ready", 32'(o_req_ready), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      check("mid_rst_ready", 32'(o_req_ready), 32'd1);
      check("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
      do_req(1'b0, 32'h40, 4'hF, 32'h0, 1'b0, rd, er, lat);
      check("w40_intact", rd, 32'hCAFE_F00D);
      check("w40_lat",    32'(lat), 32'd3);

      // Zero-latency instance
      t_sel = 1'b1;
      #1;
      do_req(1'b1, 32'h8, 4'hF, 32'h55AA_55AA, 1'b0, rd, er, lat);
      check("l0_st_lat",   32'(lat), 32'd1);
      check("l0_st_rdata", rd, 32'h55AA_55AA);
      do_req(1'b0, 32'h8, 4'hF, 32'h0, 1'b0, rd, er, lat);
      check("l0_ld_lat",   32'(lat), 32'd1);
      check("l0_ld_rdata", rd, 32'h55AA_55AA);
      do_req(1'b0, 32'h9, 4'hF, 32'h0, 1'b0, rd, er, lat);
      check("l0_mis_err",  32'(er), 32'd1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
